muldiv_hilo_unit: RTL and testbench



---
 rtl/muldiv_hilo_unit_pkg.sv | 24 ++
 rtl/muldiv_hilo_unit_core.sv | 57 +++++
 rtl/muldiv_hilo_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
// Funct codes, FSM encoding and small decode helpers.
package muldiv_hilo_unit_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) ||
               (f == FN_DIV)  || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_core.sv
// One-bit-per-cycle datapath: shift-add multiply, restoring divide.
// The {acc_hi, acc_lo} pair is the product, or remainder/quotient.
module muldiv_core
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc_hi,
    output logic [DATA_W-1:0] acc_lo
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_shl;
    logic [DATA_W-1:0] diff;
    logic              ge;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_shl = {hi_q, lo_q[DATA_W-1]};
        ge      = rem_shl >= {1'b0, b_q};
        // true difference is below the divisor, so the low bits suffice
        diff    = rem_shl[DATA_W-1:0] - b_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a;
            b_q  <= b;
        end else if (step) begin
            if (is_div) begin
                hi_q <= ge ? diff : rem_shl[DATA_W-1:0];
                lo_q <= {lo_q[DATA_W-2:0], ge};
            end else begin
                {hi_q, lo_q} <= {sum, lo_q[DATA_W-1:1]};
            end
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative mult/div engine with architectural HI/LO registers.
// Holds the FSM, iteration counter, sign handling and HI/LO.
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                op_div;
    logic                op_signed;
    logic                neg_res;
    logic                neg_rem;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [DATA_W-1:0]   core_hi;
    logic [DATA_W-1:0]   core_lo;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;
    logic                div_zero;
    logic                core_load;
    logic                core_step;

    assign core_load = (state == S_PREP);
    assign core_step = (state == S_CALC);
    assign div_zero  = (b_q == '0);

    always_comb begin
        a_abs = (op_signed && a_q[DATA_W-1]) ? -a_q : a_q;
        b_abs = (op_signed && b_q[DATA_W-1]) ? -b_q : b_q;
    end

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_div),
        .a      (a_abs),
        .b      (b_abs),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    always_comb begin
        prod   = neg_res ? -{core_hi, core_lo} : {core_hi, core_lo};
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (op_div) begin
            // divide by zero reports the original dividend, quotient all ones
            if (div_zero) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = neg_res ? -core_lo : core_lo;
                res_hi = neg_rem ? -core_hi : core_hi;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_muldiv(Funct)) begin
                        a_q       <= OpA;
                        b_q       <= OpB;
                        op_div    <= Funct[1];
                        op_signed <= ~Funct[0];
                        state     <= S_PREP;
                    end else if (start && Funct == FN_MTHI) begin
                        Hi <= OpA;
                    end else if (start && Funct == FN_MTLO) begin
                        Lo <= OpA;
                    end
                end
                S_PREP: begin
                    neg_res <= op_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                    neg_rem <= op_signed & a_q[DATA_W-1];
                    cnt     <= CW'(DATA_W);
                    state   <= S_CALC;
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    Hi    <= res_hi;
                    Lo    <= res_lo;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIX) && !flush;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed vectors,
// expected HI/LO queued at issue and checked on each done pulse.
module tb_muldiv_hilo_unit;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  Funct = '0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    muldiv_hilo_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .Funct (Funct),
        .OpA   (OpA),
        .OpB   (OpB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a done pulse means HI/LO update at the coming edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && done === 1'b1) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, Hi, e.hi);
                    chk({e.name, "_lo"}, Lo, e.lo);
                end
            end
        end
    end

    // Drive start for one edge; returns at the negedge after it.
    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        Funct = f;
        OpA   = a;
        OpB   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(inout int n);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.name = name;
        exp_q.push_back(e);
        issue(f, a, b);
        n = 0;
        wait_idle(n);
        chk({name, "_busy_cycles"}, n, 34);
    endtask

    initial begin
        int n;
        exp_t e;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        reset = 1'b1;

        run_op("mult_neg3x5", F_MULT, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg7_2", F_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2", F_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_7_0", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_op("div_neg5_0", F_DIV, 32'hFFFFFFFB, 32'd0,
               32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000);

        issue(F_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", Hi, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 0);
        issue(F_MTLO, 32'd0, 32'd0);
        chk("mtlo_lo", Lo, 0);

        // flush at cycle 10 of a mult
        issue(F_MULT, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 0);
        repeat (40) @(negedge clk);
        chk("flush_hi", Hi, 32'h1234);
        chk("flush_lo", Lo, 0);

        // flush in the FIX cycle suppresses the write
        issue(F_MULTU, 32'd9, 32'd9);
        repeat (33) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fixflush_done", {31'd0, done}, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("fixflush_busy", {31'd0, busy}, 0);
        chk("fixflush_hi", Hi, 32'h1234);
        chk("fixflush_lo", Lo, 0);

        // flush and start together: nothing latched
        @(negedge clk);
        start = 1'b1;
        Funct = F_MULT;
        OpA = 32'd2;
        OpB = 32'd2;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flushstart_busy", {31'd0, busy}, 0);

        // extra starts while busy are ignored
        e.hi = 32'd0;
        e.lo = 32'd42;
        e.name = "mult_6x7_busy";
        exp_q.push_back(e);
        issue(F_MULT, 32'd6, 32'd7);
        n = 1;
        @(negedge clk);
        start = 1'b1;
        Funct = F_DIVU;
        OpA = 32'd1;
        OpB = 32'd1;
        repeat (3) begin n++; @(negedge clk); end
        Funct = F_MTHI;
        OpA = 32'hDEAD;
        n++;
        @(negedge clk);
        start = 1'b0;
        n++;
        @(negedge clk);
        wait_idle(n);
        chk("busy_ignore_cycles", n, 34);
        repeat (3) @(negedge clk);
        chk("busy_ignore_hi", Hi, 0);

        // reset at cycle 20 of a mult
        issue(F_MTLO, 32'h5555, 32'd0);
        issue(F_MULT, 32'd11, 32'd13);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_hi", Hi, 0);
        chk("midrst_lo", Lo, 0);
        chk("midrst_done", {31'd0, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_lo_after", Lo, 0);

        run_op("mult_after_rst", F_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF,
               32'h3FFFFFFF, 32'h00000001);
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
